// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM encoding, bit-level constants.
package i2c_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned RW_BIT = 0;

    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;
    localparam logic RW_READ = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer, N-sample glitch filter and registered edge pulses for one bus line.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0]            r_sync;
    logic [FILTER_LEN-1:0] r_hist;
    logic                  r_level;
    logic                  r_rise;
    logic                  r_fall;
    logic                  w_level_nxt;

    // Level changes only once FILTER_LEN consecutive samples agree.
    always_comb begin
        w_level_nxt = r_level;
        if (&r_hist) begin
            w_level_nxt = 1'b1;
        end else if (~|r_hist) begin
            w_level_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_hist  <= '1;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_line};
            r_hist  <= FILTER_LEN'({r_hist, r_sync[1]});
            r_level <= w_level_nxt;
            r_rise  <= w_level_nxt & ~r_level;
            r_fall  <= ~w_level_nxt & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with byte-wide register port, auto-incrementing subaddress and read/write bursts.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              I2C_SCL,
    inout  wire               I2C_SDA,
    output logic [BYTE_W-1:0] REG_ADDR,
    output logic [BYTE_W-1:0] REG_WDATA,
    output logic              REG_WE,
    output logic              REG_RD,
    input  logic [BYTE_W-1:0] REG_RDATA,
    output logic              BUSY
);

    logic w_scl_f, w_scl_rise, w_scl_fall;
    logic w_sda_f, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .i_line  (I2C_SCL),
        .o_level (w_scl_f),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .i_line  (I2C_SDA),
        .o_level (w_sda_f),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl_f;
    assign w_stop  = w_sda_rise & w_scl_f;

    state_t             r_state,   w_state_nxt;
    logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [BYTE_W-1:0]  r_shift,   w_shift_nxt;
    logic [BYTE_W-1:0]  r_addr,    w_addr_nxt;
    logic [BYTE_W-1:0]  r_wdata,   w_wdata_nxt;
    logic               r_sda_oe,  w_sda_oe_nxt;
    logic               r_busy,    w_busy_nxt;
    logic               r_rw,      w_rw_nxt;
    logic               r_we,      w_we_nxt;
    logic               r_rd,      w_rd_nxt;
    logic               r_acked,   w_acked_nxt;
    logic               r_rd_dly;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_rw      <= 1'b0;
            r_we      <= 1'b0;
            r_rd      <= 1'b0;
            r_acked   <= 1'b0;
            r_rd_dly  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_rw      <= w_rw_nxt;
            r_we      <= w_we_nxt;
            r_rd      <= w_rd_nxt;
            r_acked   <= w_acked_nxt;
            r_rd_dly  <= r_rd;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_rw_nxt      = r_rw;
        w_we_nxt      = 1'b0;
        w_rd_nxt      = 1'b0;
        w_acked_nxt   = r_acked;

        if (w_start) begin
            w_state_nxt   = ST_ADDR;
            w_bit_cnt_nxt = '0;
            w_sda_oe_nxt  = 1'b0;
            w_acked_nxt   = 1'b0;
        end else if (w_stop) begin
            w_state_nxt  = ST_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else begin
            // REG_RDATA is valid two CLK after REG_RD; the first read bit goes out as soon as it lands.
            if (r_rd_dly) begin
                w_shift_nxt = REG_RDATA;
                if (r_state == ST_RD) begin
                    w_sda_oe_nxt = ~REG_RDATA[BYTE_W-1];
                end
            end

            unique case (r_state)
                ST_IDLE: ;
                ST_ADDR, ST_SUB, ST_WR: begin
                    if (w_scl_rise && (r_bit_cnt != CNT_W'(BYTE_W))) begin
                        w_shift_nxt   = {r_shift[BYTE_W-2:0], w_sda_f};
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                    if (w_scl_fall && (r_bit_cnt == CNT_W'(BYTE_W))) begin
                        if (r_state == ST_ADDR) begin
                            if (r_shift[BYTE_W-1:1] == SLAVE_ADDR) begin
                                w_sda_oe_nxt = 1'b1;
                                w_busy_nxt   = 1'b1;
                                w_rw_nxt     = r_shift[RW_BIT];
                                w_state_nxt  = ST_ADDR_ACK;
                            end else begin
                                w_sda_oe_nxt = 1'b0;
                                w_busy_nxt   = 1'b0;
                                w_state_nxt  = ST_IGNORE;
                            end
                        end else if (r_state == ST_SUB) begin
                            w_addr_nxt   = r_shift;
                            w_sda_oe_nxt = 1'b1;
                            w_state_nxt  = ST_SUB_ACK;
                        end else begin
                            w_wdata_nxt  = r_shift;
                            w_we_nxt     = 1'b1;
                            w_sda_oe_nxt = 1'b1;
                            w_state_nxt  = ST_WR_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = '0;
                        if (r_rw == RW_READ) begin
                            w_rd_nxt    = 1'b1;
                            w_state_nxt = ST_RD;
                        end else begin
                            w_state_nxt = ST_SUB;
                        end
                    end
                end
                ST_SUB_ACK, ST_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = ST_WR;
                        if (r_state == ST_WR_ACK) begin
                            w_addr_nxt = r_addr + BYTE_W'(1);
                        end
                    end
                end
                ST_RD: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == CNT_W'(BYTE_W - 1)) begin
                            w_sda_oe_nxt = 1'b0;
                            w_acked_nxt  = 1'b0;
                            w_state_nxt  = ST_RD_ACK;
                        end else begin
                            w_shift_nxt   = {r_shift[BYTE_W-2:0], 1'b0};
                            w_sda_oe_nxt  = ~r_shift[BYTE_W-2];
                            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_RD_ACK: begin
                    // A NACK ends the read; IGNORE keeps SDA released until START or STOP.
                    if (w_scl_rise) begin
                        if (w_sda_f == ACK) begin
                            w_acked_nxt = 1'b1;
                            w_rd_nxt    = 1'b1;
                            w_addr_nxt  = r_addr + BYTE_W'(1);
                        end else if (w_sda_f == NACK) begin
                            w_state_nxt = ST_IGNORE;
                        end
                    end
                    if (w_scl_fall && r_acked) begin
                        w_acked_nxt   = 1'b0;
                        w_bit_cnt_nxt = '0;
                        w_sda_oe_nxt  = ~r_shift[BYTE_W-1];
                        w_state_nxt   = ST_RD;
                    end
                end
                ST_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign I2C_SDA   = r_sda_oe ? 1'b0 : 1'bz;
    assign REG_ADDR  = r_addr;
    assign REG_WDATA = r_wdata;
    assign REG_WE    = r_we;
    assign REG_RD    = r_rd;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged bus master, register-file model and pulse monitor.
module tb_i2c_slave;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       m_low;
    logic       glitch_en;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_rd, busy;
    logic [7:0] mem [256];
    wire        sda_bus;

    int checks = 0;
    int errors = 0;

    logic [15:0] we_q [$];
    logic [7:0]  rd_q [$];

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);
    assign reg_rdata = mem[reg_addr];

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .I2C_SCL   (scl),
        .I2C_SDA   (sda_bus),
        .REG_ADDR  (reg_addr),
        .REG_WDATA (reg_wdata),
        .REG_WE    (reg_we),
        .REG_RD    (reg_rd),
        .REG_RDATA (reg_rdata),
        .BUSY      (busy)
    );

    always @(negedge clk) begin
        if (reg_we) we_q.push_back({reg_addr, reg_wdata});
        if (reg_rd) rd_q.push_back(reg_addr);
        if (reg_we || reg_rd) begin
            checks++;
            assert (!(reg_we && reg_rd)) else begin
                errors++;
                $error("FAIL we_rd_overlap obs=%b%b exp=not both", reg_we, reg_rd);
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bit(input logic b, output logic s);
        if (glitch_en) begin
            wait_clk(Q/2);
            scl = 1'b1;
            wait_clk(1);
            scl = 1'b0;
            wait_clk(Q - Q/2 - 1);
        end else begin
            wait_clk(Q);
        end
        m_low = ~b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        s = sda_bus;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) xfer_bit(d[i], dummy);
        xfer_bit(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic dummy;
        for (int i = 7; i >= 0; i--) xfer_bit(1'b1, d[i]);
        xfer_bit(nack, dummy);
    endtask

    task automatic start_cond();
        if (scl == 1'b0) begin
            wait_clk(Q);
            m_low = 1'b0;
            wait_clk(Q);
            scl = 1'b1;
            wait_clk(Q);
        end
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic stop_cond();
        wait_clk(Q);
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_low = 1'b0;
        wait_clk(2*Q);
    endtask

    initial begin
        logic       ack, dummy;
        logic [7:0] d0, d1;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h30] = 8'h3C;
        mem[8'h31] = 8'h5A;
        rst_n = 1'b0; scl = 1'b1; m_low = 1'b0; glitch_en = 1'b0;

        wait_clk(5);
        check("rst_addr",  16'(reg_addr), 16'h00);
        check("rst_wdata", 16'(reg_wdata), 16'h00);
        check("rst_we",    16'(reg_we), 16'h0);
        check("rst_rd",    16'(reg_rd), 16'h0);
        check("rst_busy",  16'(busy), 16'h0);
        check("rst_sda",   16'(sda_bus), 16'h1);
        rst_n = 1'b1;
        wait_clk(20);

        // Single write
        we_q.delete(); rd_q.delete();
        start_cond();
        write_byte(8'hA0, ack); check("wr_addr_ack", 16'(ack), 16'h0);
        check("wr_busy", 16'(busy), 16'h1);
        write_byte(8'h12, ack); check("wr_sub_ack", 16'(ack), 16'h0);
        write_byte(8'hA5, ack); check("wr_data_ack", 16'(ack), 16'h0);
        stop_cond();
        check("wr_we_cnt", 16'(we_q.size()), 16'd1);
        check("wr_we0", we_q[0], 16'h12A5);
        check("wr_addr_inc", 16'(reg_addr), 16'h13);
        check("wr_busy_stop", 16'(busy), 16'h0);

        // Subaddress write, repeated START, single-byte read with NACK
        we_q.delete(); rd_q.delete();
        start_cond();
        write_byte(8'hA0, ack); check("rd_addrw_ack", 16'(ack), 16'h0);
        write_byte(8'h30, ack); check("rd_sub_ack", 16'(ack), 16'h0);
        start_cond();
        write_byte(8'hA1, ack); check("rd_addrr_ack", 16'(ack), 16'h0);
        read_byte(d0, 1'b1);
        stop_cond();
        check("rd_data", 16'(d0), 16'h3C);
        check("rd_rd_cnt", 16'(rd_q.size()), 16'd1);
        check("rd_rd0", 16'(rd_q[0]), 16'h30);
        check("rd_we_cnt", 16'(we_q.size()), 16'd0);
        check("rd_addr_hold", 16'(reg_addr), 16'h30);

        // Two-byte read from the current pointer, no subaddress
        we_q.delete(); rd_q.delete();
        start_cond();
        write_byte(8'hA1, ack); check("rd2_addr_ack", 16'(ack), 16'h0);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        stop_cond();
        check("rd2_d0", 16'(d0), 16'h3C);
        check("rd2_d1", 16'(d1), 16'h5A);
        check("rd2_rd_cnt", 16'(rd_q.size()), 16'd2);
        check("rd2_rd1", 16'(rd_q[1]), 16'h31);

        // Burst write across the 0xFF -> 0x00 wrap
        we_q.delete(); rd_q.delete();
        start_cond();
        write_byte(8'hA0, ack); check("bw_addr_ack", 16'(ack), 16'h0);
        write_byte(8'hFE, ack); check("bw_sub_ack", 16'(ack), 16'h0);
        write_byte(8'h11, ack); check("bw_d0_ack", 16'(ack), 16'h0);
        write_byte(8'h22, ack); check("bw_d1_ack", 16'(ack), 16'h0);
        write_byte(8'h33, ack); check("bw_d2_ack", 16'(ack), 16'h0);
        stop_cond();
        check("bw_we_cnt", 16'(we_q.size()), 16'd3);
        check("bw_we0", we_q[0], 16'hFE11);
        check("bw_we1", we_q[1], 16'hFF22);
        check("bw_we2", we_q[2], 16'h0033);
        check("bw_addr", 16'(reg_addr), 16'h01);

        // Foreign address 0x51, then a normal write
        we_q.delete(); rd_q.delete();
        start_cond();
        write_byte(8'hA2, ack); check("na_addr_nack", 16'(ack), 16'h1);
        check("na_busy", 16'(busy), 16'h0);
        write_byte(8'h12, ack); check("na_sub_nack", 16'(ack), 16'h1);
        write_byte(8'h77, ack); check("na_data_nack", 16'(ack), 16'h1);
        stop_cond();
        check("na_we_cnt", 16'(we_q.size()), 16'd0);
        check("na_rd_cnt", 16'(rd_q.size()), 16'd0);
        start_cond();
        write_byte(8'hA0, ack); check("na2_addr_ack", 16'(ack), 16'h0);
        write_byte(8'h40, ack); check("na2_sub_ack", 16'(ack), 16'h0);
        write_byte(8'h99, ack); check("na2_data_ack", 16'(ack), 16'h0);
        stop_cond();
        check("na2_we_cnt", 16'(we_q.size()), 16'd1);
        check("na2_we0", we_q[0], 16'h4099);

        // One-CLK SCL glitches in every low phase of the subaddress byte
        we_q.delete(); rd_q.delete();
        start_cond();
        write_byte(8'hA0, ack); check("gl_addr_ack", 16'(ack), 16'h0);
        glitch_en = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            d0 = 8'h5C;
            xfer_bit(d0[i], dummy);
        end
        glitch_en = 1'b0;
        xfer_bit(1'b1, ack); check("gl_sub_ack", 16'(ack), 16'h0);
        write_byte(8'h6B, ack); check("gl_data_ack", 16'(ack), 16'h0);
        stop_cond();
        check("gl_we_cnt", 16'(we_q.size()), 16'd1);
        check("gl_we0", we_q[0], 16'h5C6B);
        check("gl_addr", 16'(reg_addr), 16'h5D);

        // Asynchronous reset while the target holds ACK low
        start_cond();
        d0 = 8'hA0;
        for (int i = 7; i >= 0; i--) xfer_bit(d0[i], dummy);
        m_low = 1'b0;
        wait_clk(Q);
        check("ar_ack_driven", 16'(sda_bus), 16'h0);
        rst_n = 1'b0;
        #1;
        check("ar_sda_rel", 16'(sda_bus), 16'h1);
        check("ar_busy", 16'(busy), 16'h0);
        check("ar_addr", 16'(reg_addr), 16'h00);
        check("ar_wdata", 16'(reg_wdata), 16'h00);
        check("ar_we_rd", {14'h0, reg_we, reg_rd}, 16'h0);
        wait_clk(2);
        scl = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(20);
        we_q.delete(); rd_q.delete();
        start_cond();
        write_byte(8'hA0, ack); check("ar2_addr_ack", 16'(ack), 16'h0);
        write_byte(8'h21, ack); check("ar2_sub_ack", 16'(ack), 16'h0);
        write_byte(8'hC3, ack); check("ar2_data_ack", 16'(ack), 16'h0);
        stop_cond();
        check("ar2_we_cnt", 16'(we_q.size()), 16'd1);
        check("ar2_we0", we_q[0], 16'h21C3);
        check("ar2_addr", 16'(reg_addr), 16'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
